// File: rtl/shift_norm_pkg.sv
// ----------------------------------------------------------------------------
// shift_norm_pkg
//   Shared definitions for the shift normalizer.
//   - norm_state_t : FSM state encoding (IDLE / SHIFT / DONE), also used by
//                    the debug state output so checkers can bind to it.
// ----------------------------------------------------------------------------
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage : shift_norm_pkg

// File: rtl/shift_normalizer.sv
// ----------------------------------------------------------------------------
// shift_normalizer
//   Iterative normalizer: shifts an operand one bit per cycle until its most
//   significant bit is set, reporting the number of positions shifted, so
//   that (o >> shamt) == operand. A zero operand finishes immediately with
//   zero=1, o=0 and shamt=0.
//
//   Optional feature (macro SHIFT_NORM_DIR_EN): adds input 'shope' sampled at
//   accept; shope=1 normalizes left (as above), shope=0 normalizes right
//   until o[0]=1 with shamt = trailing-zero count, so (o << shamt) == operand.
//   Without the macro the port is absent and only left normalization exists.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   i_valid    in   operand offered
//   i_ready    out  block accepts an operand (IDLE only)
//   i_1        in   operand [WIDTH]
//   shope      in   direction, 1=left 0=right (SHIFT_NORM_DIR_EN only)
//   o_valid    out  result valid (DONE only)
//   o_ready    in   consumer accepts result
//   o          out  normalized value [WIDTH]
//   shamt      out  shift count applied [SHAMT_WIDTH]
//   zero       out  operand was all zeros
//   dbg_state  out  current FSM state, for debug/checkers
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. Input and output never overlap: i_ready
// is only high in IDLE and o_valid only in DONE, so the next operand is taken
// at the earliest one cycle after the output transfer.
// ----------------------------------------------------------------------------
module shift_normalizer
    import shift_norm_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [WIDTH-1:0]       i_1,
`ifdef SHIFT_NORM_DIR_EN
    input  logic                   shope,
`endif
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WIDTH-1:0]       o,
    output logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   zero,
    output norm_state_t            dbg_state
);

    norm_state_t            state_q;
    logic [WIDTH-1:0]       work_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   zero_q;

    // Datapath next values for one SHIFT step.
    logic [WIDTH-1:0]       work_d;
    logic [SHAMT_WIDTH-1:0] cnt_d;
    logic                   aligned;

`ifdef SHIFT_NORM_DIR_EN
    logic dir_q;  // 1 = left, 0 = right; latched at accept

    always_comb begin
        work_d  = '0;
        aligned = 1'b0;
        if (dir_q) begin
            work_d  = {work_q[WIDTH-2:0], 1'b0};
            aligned = work_q[WIDTH-1];
        end else begin
            work_d  = {1'b0, work_q[WIDTH-1:1]};
            aligned = work_q[0];
        end
    end
`else
    always_comb begin
        work_d  = {work_q[WIDTH-2:0], 1'b0};
        aligned = work_q[WIDTH-1];
    end
`endif

    // A nonzero operand reaches alignment after at most WIDTH-1 steps, so the
    // counter cannot wrap; no saturation logic is needed.
    assign cnt_d = cnt_q + SHAMT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
`ifdef SHIFT_NORM_DIR_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        work_q  <= i_1;
                        cnt_q   <= '0;
                        zero_q  <= (i_1 == '0);
`ifdef SHIFT_NORM_DIR_EN
                        dir_q   <= shope;
`endif
                        // A zero operand can never align; report it directly.
                        state_q <= (i_1 == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (aligned) begin
                        state_q <= DONE;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_d;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers, so reset clears them at once.
    assign i_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o         = work_q;
    assign shamt     = cnt_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule : shift_normalizer

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;
    import shift_norm_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic [W-1:0]  i_1 = '0;
`ifdef SHIFT_NORM_DIR_EN
    logic          shope = 1'b1;
`endif
    logic          i_ready;
    logic          o_valid;
    logic [W-1:0]  o;
    logic [SW-1:0] shamt;
    logic          zero;
    norm_state_t   dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_normalizer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_1       (i_1),
`ifdef SHIFT_NORM_DIR_EN
        .shope     (shope),
`endif
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o         (o),
        .shamt     (shamt),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog global time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (no checking) ----------------
    // Offer v for one edge, then scramble i_1 and count edges from the accept
    // edge until o_valid is seen. lat = -1 if the budget runs out.
    task automatic offer(input logic [W-1:0] v, output int lat);
        @(negedge clk);
        i_valid = 1'b1;
        i_1     = v;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_1     = $urandom;
        lat     = 1;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!o_valid) lat = -1;
    endtask

    // Complete the output handshake; returns #1 after the transfer edge.
    task automatic drain();
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready got=%b exp=1", i_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o !== 32'h0) begin failures++; $display("FAIL reset_o got=%h exp=00000000", o); end
        checks++; if (shamt !== 5'd0) begin failures++; $display("FAIL reset_shamt got=%0d exp=0", shamt); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lsb();
        int lat;
        offer(32'h0000_0001, lat);
        checks++; if (lat !== 33) begin failures++; $display("FAIL lsb_latency got=%0d exp=33", lat); end
        checks++; if (o !== 32'h8000_0000) begin failures++; $display("FAIL lsb_o got=%h exp=80000000", o); end
        checks++; if (shamt !== 5'd31) begin failures++; $display("FAIL lsb_shamt got=%0d exp=31", shamt); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL lsb_zero got=%b exp=0", zero); end
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL lsb_i_ready_done got=%b exp=0", i_ready); end
        drain();
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin failures++; $display("FAIL lsb_after_hs o_valid=%b i_ready=%b exp 0/1", o_valid, i_ready); end
    endtask

    task automatic test_msb();
        int lat;
        offer(32'h8000_0000, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL msb_latency got=%0d exp=2", lat); end
        checks++; if (o !== 32'h8000_0000) begin failures++; $display("FAIL msb_o got=%h exp=80000000", o); end
        checks++; if (shamt !== 5'd0) begin failures++; $display("FAIL msb_shamt got=%0d exp=0", shamt); end
        drain();
        offer(32'hDEAD_BEEF, lat);
        checks++; if (lat !== 2 || o !== 32'hDEAD_BEEF || shamt !== 5'd0) begin failures++; $display("FAIL dead_vec lat=%0d o=%h shamt=%0d exp 2/deadbeef/0", lat, o, shamt); end
        drain();
        offer(32'h00F0_0000, lat);
        checks++; if (lat !== 10 || o !== 32'hF000_0000 || shamt !== 5'd8) begin failures++; $display("FAIL f0_vec lat=%0d o=%h shamt=%0d exp 10/f0000000/8", lat, o, shamt); end
        drain();
    endtask

    task automatic test_zero();
        int lat;
        offer(32'h0000_0000, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if (o !== 32'h0) begin failures++; $display("FAIL zero_o got=%h exp=00000000", o); end
        checks++; if (shamt !== 5'd0) begin failures++; $display("FAIL zero_shamt got=%0d exp=0", shamt); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b exp=1", zero); end
        drain();
        // A following nonzero operand must clear the zero flag.
        offer(32'h0000_8000, lat);
        checks++; if (zero !== 1'b0 || shamt !== 5'd16 || o !== 32'h8000_0000) begin failures++; $display("FAIL zero_clear zero=%b shamt=%0d o=%h exp 0/16/80000000", zero, shamt, o); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        offer(32'h0001_2345, lat);
        checks++; if (lat !== 17) begin failures++; $display("FAIL bp_latency got=%0d exp=17", lat); end
        // Operand offered during DONE must be ignored.
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_1 = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (o !== 32'h91A2_8000 || shamt !== 5'd15 || o_valid !== 1'b1 || i_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d o=%h shamt=%0d o_valid=%b i_ready=%b exp 91a28000/15/1/0", c, o, shamt, o_valid, i_ready);
            end
        end
        i_valid = 1'b0;
        drain();
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin failures++; $display("FAIL bp_release o_valid=%b i_ready=%b exp 0/1", o_valid, i_ready); end
    endtask

    task automatic test_first_cycle_ready();
        int lat;
        o_ready = 1'b1;
        offer(32'h4000_0000, lat);
        checks++; if (lat !== 3 || o !== 32'h8000_0000 || shamt !== 5'd1) begin failures++; $display("FAIL fcr_result lat=%0d o=%h shamt=%0d exp 3/80000000/1", lat, o, shamt); end
        @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin failures++; $display("FAIL fcr_single_cycle o_valid=%b i_ready=%b exp 0/1", o_valid, i_ready); end
        o_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        o_ready = 1'b1;
        offer(32'h0000_00F0, lat);
        checks++; if (lat !== 26 || o !== 32'hF000_0000 || shamt !== 5'd24) begin failures++; $display("FAIL b2b_first lat=%0d o=%h shamt=%0d exp 26/f0000000/24", lat, o, shamt); end
        @(negedge clk);
        i_valid = 1'b1;
        i_1     = 32'h0000_00FF;
        @(posedge clk);  // output transfer edge: must not accept
        #1;
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_overlap o_valid=%b i_ready=%b exp 0/1", o_valid, i_ready); end
        @(posedge clk);  // accept edge
        #1;
        i_valid = 1'b0;
        i_1     = $urandom;
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept i_ready=%b exp 0", i_ready); end
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 26 || o !== 32'hFF00_0000 || shamt !== 5'd24) begin failures++; $display("FAIL b2b_second lat=%0d o=%h shamt=%0d exp 26/ff000000/24", lat, o, shamt); end
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        i_valid = 1'b1;
        i_1     = 32'h0000_00FF;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_shift o_valid=%b i_ready=%b exp 0/0", o_valid, i_ready); end
        #2;
        rst = 1'b1;  // between edges
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o !== 32'h0 || shamt !== 5'd0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async o_valid=%b i_ready=%b o=%h shamt=%0d zero=%b exp 0/1/0/0/0", o_valid, i_ready, o, shamt, zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        offer(32'h0000_0F00, lat);
        checks++; if (lat !== 22 || o !== 32'hF000_0000 || shamt !== 5'd20) begin failures++; $display("FAIL rmid_after lat=%0d o=%h shamt=%0d exp 22/f0000000/20", lat, o, shamt); end
        drain();
    endtask

`ifdef SHIFT_NORM_DIR_EN
    task automatic test_right();
        int lat;
        @(negedge clk);
        shope = 1'b0;
        offer(32'h0000_0100, lat);
        shope = 1'b1;
        checks++; if (lat !== 10 || o !== 32'h0000_0001 || shamt !== 5'd8) begin failures++; $display("FAIL right_vec lat=%0d o=%h shamt=%0d exp 10/00000001/8", lat, o, shamt); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_lsb();
        test_msb();
        test_zero();
        test_backpressure();
        test_first_cycle_ready();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIFT_NORM_DIR_EN
        test_right();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_normalizer
